uart_io_responder: RTL and testbench

Serving end of the core's UART request channel. Accepts single-word read or write orders from the io core over the order/accepted/done handshake and serialises them as 1–4 byte transfers. Writes go out on a byte-wide transmitter stream; reads are returned from a receive FIFO filled by the UART receiver. Sits between the io core request port and the physical UART tx/rx byte engines.

---
 rtl/uart_io_responder_if.sv | 31 +++
 rtl/uart_io_responder.sv | 193 +++++++++++++++++++
 tb/tb_uart_io_responder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_responder_if.sv
// Request channel between the io core (master) and the UART responder (slave):
// order/accepted/done handshake plus write and read data words.
interface uart_io_responder_if;
   logic        order;
   logic [1:0]  size;
   logic        write_flag;
   logic [31:0] o_data;
   logic        accepted;
   logic        done;
   logic [31:0] i_data;

   modport master (
      output order,
      output size,
      output write_flag,
      output o_data,
      input  accepted,
      input  done,
      input  i_data
   );

   modport slave (
      input  order,
      input  size,
      input  write_flag,
      input  o_data,
      output accepted,
      output done,
      output i_data
   );
endinterface

// File: rtl/uart_io_responder.sv
// UART request responder: serialises 1-4 byte writes to the tx stream, assembles reads from rx.
// Optional macro UART_IO_RX_FIFO_EN selects a DEPTH-entry receive FIFO instead of one byte.
module uart_io_responder #(
   parameter int unsigned DEPTH = 16
) (
   input  logic               clk,
   input  logic               rstn,
   uart_io_responder_if.slave bus,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_overflow
);

   typedef enum logic [1:0] {StIdle, StTx, StRx, StFin} state_e;

   state_e      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] idata_q, idata_d;
   logic        done_q, done_d;
   logic        txv_q, txv_d;
   logic [7:0]  txd_q, txd_d;
   logic        ovf_q, ovf_d;

   logic        fifo_empty;
   logic        fifo_full;
   logic        fifo_pop;
   logic        fifo_push;
   logic [7:0]  fifo_rdata;

   // Popping uses the registered empty flag, so a byte pushed this cycle is never bypassed.
   assign fifo_pop  = (state_q == StRx) && !fifo_empty;
   assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

`ifdef UART_IO_RX_FIFO_EN
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [7:0]  mem_q [DEPTH];

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign fifo_rdata = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q + {{AW{1'b0}}, fifo_push};
      rptr_d = rptr_q + {{AW{1'b0}}, fifo_pop};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         mem_q[wptr_q[AW-1:0]] <= rx_data;
      end
   end
`else
   logic [7:0] buf_q, buf_d;
   logic       full_q, full_d;
   logic       unused_depth;

   assign unused_depth = ^DEPTH;
   assign fifo_empty   = !full_q;
   assign fifo_full    = full_q;
   assign fifo_rdata   = buf_q;

   always_comb begin
      buf_d  = buf_q;
      full_d = full_q;
      if (fifo_pop) begin
         full_d = 1'b0;
      end
      if (fifo_push) begin
         buf_d  = rx_data;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_q  <= 8'h00;
         full_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         full_q <= full_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      idata_d = idata_q;
      ovf_d   = ovf_q | (rx_valid & fifo_full & ~fifo_pop);

      unique case (state_q)
         StIdle: begin
            if (bus.order) begin
               size_d  = bus.size;
               wdata_d = bus.o_data;
               cnt_d   = 2'd0;
               if (bus.write_flag) begin
                  state_d = StTx;
               end else begin
                  state_d = StRx;
                  // Lanes above the requested size read back as zero.
                  for (int i = 1; i < 4; i++) begin
                     if (i > int'(bus.size)) begin
                        idata_d[8*i +: 8] = 8'h00;
                     end
                  end
               end
            end
         end
         StTx: begin
            if (tx_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == size_q) begin
                  state_d = StFin;
               end
            end
         end
         StRx: begin
            if (fifo_pop) begin
               idata_d[{cnt_q, 3'b000} +: 8] = fifo_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == size_q) begin
                  state_d = StFin;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      done_d = (state_d == StFin);
      txv_d  = (state_d == StTx);
      txd_d  = txv_d ? wdata_d[{cnt_d, 3'b000} +: 8] : 8'h00;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         size_q  <= 2'd0;
         cnt_q   <= 2'd0;
         wdata_q <= 32'h0;
         idata_q <= 32'h0;
         done_q  <= 1'b0;
         txv_q   <= 1'b0;
         txd_q   <= 8'h00;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         idata_q <= idata_d;
         done_q  <= done_d;
         txv_q   <= txv_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.accepted = (state_q == StIdle) && bus.order;
   assign bus.done     = done_q;
   assign bus.i_data   = idata_q;
   assign tx_valid     = txv_q;
   assign tx_data      = txd_q;
   assign rx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_io_responder.sv
// Bench for uart_io_responder: directed vector table, corner sequences and random
// transactions checked against a queue-based model of the receive buffer.
module tb_uart_io_responder;
   localparam int unsigned DEPTH = 16;
`ifdef UART_IO_RX_FIFO_EN
   localparam int CAP = DEPTH;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_overflow;

   always #5 clk = ~clk;

   uart_io_responder_if dif ();

   uart_io_responder #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (dif),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_overflow (rx_overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: receive buffer contents, sticky overflow, last read word.
   logic [7:0]  q[$];
   bit          ovf_m;
   logic [31:0] last_word;

   logic        s_acc, s_done, s_txv, s_ovf;
   logic [7:0]  s_txd;
   logic [31:0] s_idata;

   typedef struct {
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] wd;
      logic [31:0] feed;
      int          fcnt;
      int          foff;
      int          gap;
      int          stall;
      logic [31:0] exp_word;
      int          exp_done;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] got;
   logic [31:0] exp_w;
   int          dc;
   int          nidle;
   int          k;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      s_acc   = dif.accepted;
      s_done  = dif.done;
      s_idata = dif.i_data;
      s_txv   = tx_valid;
      s_txd   = tx_data;
      s_ovf   = rx_overflow;
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input bit v, input logic [7:0] d);
      if (v) begin
         if (q.size() < CAP) q.push_back(d);
         else ovf_m = 1'b1;
      end
   endtask

   task automatic idle_cycle(input bit v, input logic [7:0] d);
      dif.order = 1'b0;
      rx_valid  = v;
      rx_data   = d;
      tx_ready  = 1'($urandom_range(1));
      tick();
      chk("idle_accepted", 32'(s_acc), 32'h0);
      chk("idle_done", 32'(s_done), 32'h0);
      chk("idle_tx_valid", 32'(s_txv), 32'h0);
      chk("idle_i_data", s_idata, last_word);
      chk("idle_overflow", 32'(s_ovf), 32'(ovf_m));
      model_push(v, d);
   endtask

   // Cycle 0 is the accept cycle; feed bytes land at cycles foff + j*gap.
   task automatic do_txn(input bit wr, input logic [1:0] sz, input logic [31:0] wd,
                         input logic [31:0] feed, input int fcnt, input int foff,
                         input int gap, input int stall, input int rdy_pct, input int noise_pct,
                         output logic [31:0] got_o, output int done_o);
      int          n;
      int          sent;
      int          rem;
      int          c;
      bit          fin_next;
      bit          finished;
      bit          fv;
      logic [7:0]  fd;
      logic [31:0] acc;
      n        = int'(sz) + 1;
      sent     = 0;
      rem      = n;
      c        = 0;
      fin_next = 1'b0;
      finished = 1'b0;
      acc      = 32'h0;
      got_o    = 32'h0;
      done_o   = -1;
      while (!finished && c < 300) begin
         fv = 1'b0;
         fd = 8'($urandom);
         if (gap > 0 && c >= foff && (c - foff) % gap == 0 && (c - foff) / gap < fcnt) begin
            fv = 1'b1;
            fd = feed[8*((c - foff) / gap) +: 8];
         end else if (int'($urandom_range(99)) < noise_pct) begin
            fv = 1'b1;
         end
         rx_valid = fv;
         rx_data  = fd;
         tx_ready = (c >= 1 && c <= stall) ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
         if (c == 0) begin
            dif.order      = 1'b1;
            dif.write_flag = wr;
            dif.size       = sz;
            dif.o_data     = wd;
         end else begin
            // Orders while busy must be ignored.
            dif.order      = 1'($urandom_range(1));
            dif.write_flag = 1'($urandom_range(1));
            dif.size       = 2'($urandom_range(3));
            dif.o_data     = $urandom;
         end
         tick();
         chk("overflow", 32'(s_ovf), 32'(ovf_m));
         if (c == 0) begin
            chk("accept", 32'(s_acc), 32'h1);
            chk("accept_done", 32'(s_done), 32'h0);
            chk("accept_tx_valid", 32'(s_txv), 32'h0);
         end else begin
            chk("busy_accepted", 32'(s_acc), 32'h0);
            chk("done", 32'(s_done), 32'(fin_next));
            if (fin_next) begin
               finished = 1'b1;
               done_o   = c;
               chk("fin_tx_valid", 32'(s_txv), 32'h0);
               if (wr) begin
                  got_o = acc;
               end else begin
                  chk("read_word", s_idata, acc);
                  last_word = acc;
                  got_o     = s_idata;
               end
            end else if (wr) begin
               chk("tx_valid", 32'(s_txv), 32'h1);
               chk("tx_data", 32'(s_txd), 32'(wd[8*sent +: 8]));
               if (tx_ready) begin
                  acc[8*sent +: 8] = s_txd;
                  sent++;
                  if (sent == n) fin_next = 1'b1;
               end
            end else begin
               chk("read_tx_valid", 32'(s_txv), 32'h0);
               if (q.size() > 0) begin
                  acc[8*(n - rem) +: 8] = q.pop_front();
                  rem--;
                  if (rem == 0) fin_next = 1'b1;
               end
            end
         end
         model_push(fv, fd);
         c++;
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout: got no done after %0d cycles, required done", c);
      end
      dif.order = 1'b0;
      rx_valid  = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      dif.order      = 1'b0;
      dif.size       = 2'd0;
      dif.write_flag = 1'b0;
      dif.o_data     = 32'h0;
      tx_ready       = 1'b0;
      rx_valid       = 1'b0;
      rx_data        = 8'h00;
      ovf_m          = 1'b0;
      last_word      = 32'h0;
      rstn           = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_accepted", 32'(dif.accepted), 32'h0);
      chk("rst_done", 32'(dif.done), 32'h0);
      chk("rst_i_data", dif.i_data, 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_overflow", 32'(rx_overflow), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      vecs[0] = '{1'b1, 2'd3, 32'h44332211, 32'h0, 0, 0, 0, 0, 32'h44332211, 5};
      vecs[1] = '{1'b1, 2'd0, 32'h000000A5, 32'h0, 0, 0, 0, 3, 32'h000000A5, 5};
      vecs[2] = '{1'b0, 2'd3, 32'h0, 32'h04030201, 4, 0, 5, 0, 32'h04030201, 17};
      vecs[3] = '{1'b0, 2'd3, 32'h0, 32'hFFEEDDCC, 4, 0, 1, 0, 32'hFFEEDDCC, 5};
      vecs[4] = '{1'b0, 2'd2, 32'h0, 32'h77665544, 3, 0, 1, 0, 32'h00665544, 4};
      vecs[5] = '{1'b0, 2'd0, 32'h0, 32'h00000012, 1, 0, 1, 0, 32'h00000012, 2};
      vecs[6] = '{1'b1, 2'd1, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 32'h0000BEEF, 3};
      vecs[7] = '{1'b1, 2'd2, 32'hCAFEF00D, 32'h0, 0, 0, 0, 2, 32'h00FEF00D, 6};

      foreach (vecs[i]) begin
         do_txn(vecs[i].wr, vecs[i].sz, vecs[i].wd, vecs[i].feed, vecs[i].fcnt, vecs[i].foff,
                vecs[i].gap, vecs[i].stall, 100, 0, got, dc);
         chk("vec_word", got, vecs[i].exp_word);
         chk("vec_done_cycle", 32'(dc), 32'(vecs[i].exp_done));
         idle_cycle(1'b0, 8'h00);
      end

      // Byte pushed while idle is kept; second byte arrives while the first is popped.
      idle_cycle(1'b1, 8'h0D);
      do_txn(1'b0, 2'd1, 32'h0, 32'h000000C0, 1, 1, 1, 0, 100, 0, got, dc);
      chk("idle_push_word", got, 32'h0000C00D);
      chk("idle_push_done", 32'(dc), 32'd3);
      do_txn(1'b0, 2'd0, 32'h0, 32'h0000003C, 1, 2, 1, 0, 100, 0, got, dc);
      chk("empty_after_read_word", got, 32'h0000003C);
      chk("empty_after_read_done", 32'(dc), 32'd4);

      // Overflow: one byte more than the buffer holds, then drain in order.
      for (int i = 0; i <= CAP; i++) idle_cycle(1'b1, 8'(8'h80 + i));
      idle_cycle(1'b0, 8'h00);
      chk("overflow_sticky", 32'(s_ovf), 32'h1);
      for (int b = 0; b < CAP; b += 4) begin
         k     = (CAP - b >= 4) ? 4 : CAP - b;
         exp_w = 32'h0;
         for (int j = 0; j < k; j++) exp_w[8*j +: 8] = 8'(8'h80 + b + j);
         do_txn(1'b0, 2'(k - 1), 32'h0, 32'h0, 0, 0, 0, 0, 100, 0, got, dc);
         chk("overflow_read_word", got, exp_w);
         chk("overflow_read_done", 32'(dc), 32'(k + 1));
      end

      repeat (60) begin
         nidle = $urandom_range(3);
         for (int i = 0; i < nidle; i++) idle_cycle(1'($urandom_range(1)), 8'($urandom));
         do_txn(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, 32'h0, 0, 0, 0, 0,
                60, 30, got, dc);
      end

      // Reset in the middle of a read: outputs drop at once, buffer is discarded.
      dif.order      = 1'b1;
      dif.write_flag = 1'b0;
      dif.size       = 2'd3;
      rx_valid       = 1'b1;
      rx_data        = 8'hEE;
      tick();
      dif.order = 1'b0;
      tick();
      rx_valid = 1'b0;
      tick();
      #3;
      rstn = 1'b0;
      #1;
      chk("midrst_accepted", 32'(dif.accepted), 32'h0);
      chk("midrst_done", 32'(dif.done), 32'h0);
      chk("midrst_i_data", dif.i_data, 32'h0);
      chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
      chk("midrst_tx_data", 32'(tx_data), 32'h0);
      chk("midrst_overflow", 32'(rx_overflow), 32'h0);
      q.delete();
      ovf_m     = 1'b0;
      last_word = 32'h0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      idle_cycle(1'b0, 8'h00);
      do_txn(1'b0, 2'd0, 32'h0, 32'h0000005A, 1, 0, 1, 0, 100, 0, got, dc);
      chk("post_reset_word", got, 32'h0000005A);
      chk("post_reset_done", 32'(dc), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
